// File: rtl/boss_game_pkg.sv
// Shared definitions for the boss-fight game logic: hit-detector FSM states,
// visible screen limits and default player health.
package boss_game_pkg;

  typedef enum logic [1:0] {
    ARMED  = 2'd0,
    INVULN = 2'd1,
    DEAD   = 2'd2
  } hit_state_t;

  localparam int SCREEN_W           = 640;
  localparam int SCREEN_H           = 480;
  localparam int DEFAULT_MAX_HEALTH = 5;

endpackage

// File: rtl/frame_edge_detect.sv
// Turns the slow vertical-sync frame_clk into a single-Clk frame_edge pulse
// on each rising edge of frame_clk.
module frame_edge_detect (
  input  logic Clk,
  input  logic Reset,
  input  logic frame_clk,
  output logic frame_edge
);

  logic frame_d;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      frame_d    <= 1'b0;
      frame_edge <= 1'b0;
    end else begin
      frame_d    <= frame_clk;
      frame_edge <= frame_clk & ~frame_d;
    end
  end

endmodule

// File: rtl/projectile_hit_detector.sv
// Per-frame player/projectile collision detector with health and invulnerability.
// Optional HIT_FLASH_EN: blink the player sprite while invulnerable.
module projectile_hit_detector
  import boss_game_pkg::*;
#(
  parameter int NUM_PROJ      = 4,
  parameter int MAX_HEALTH    = DEFAULT_MAX_HEALTH,
  parameter int INVULN_FRAMES = 60
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                frame_clk,
  input  logic [9:0]          DrawX,
  input  logic [9:0]          DrawY,
  input  logic                is_player,
  input  logic [NUM_PROJ-1:0] is_missile,
  output logic [NUM_PROJ-1:0] is_hit,
  output logic [2:0]          player_health,
  output logic                player_dead,
  output logic                hit_flash,
  output logic [1:0]          dbg_state
);

  // Counter needs at least 3 bits so bit 2 exists for the blink pattern.
  localparam int CNT_RAW = $clog2(INVULN_FRAMES + 1);
  localparam int CNT_W   = (CNT_RAW < 3) ? 3 : CNT_RAW;

  logic                frame_edge;
  logic                on_screen;
  logic [NUM_PROJ-1:0] sample;
  logic [NUM_PROJ-1:0] overlap_q;
  hit_state_t          state_q, state_d;
  logic [2:0]          health_q, health_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_PROJ-1:0] hit_q, hit_d;

  frame_edge_detect u_frame_edge (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_clk  (frame_clk),
    .frame_edge (frame_edge)
  );

  assign on_screen = (DrawX < 10'(SCREEN_W)) && (DrawY < 10'(SCREEN_H));
  assign sample    = (is_player && on_screen) ? is_missile : '0;

  // The sample taken on the edge cycle already belongs to the new frame.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      overlap_q <= '0;
    end else if (frame_edge) begin
      overlap_q <= sample;
    end else begin
      overlap_q <= overlap_q | sample;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= ARMED;
      health_q <= 3'(MAX_HEALTH);
      cnt_q    <= '0;
      hit_q    <= '0;
    end else begin
      state_q  <= state_d;
      health_q <= health_d;
      cnt_q    <= cnt_d;
      hit_q    <= hit_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    health_d = health_q;
    cnt_d    = cnt_q;
    hit_d    = '0;
    if (frame_edge) begin
      case (state_q)
        ARMED: begin
          hit_d = overlap_q;
          if (|overlap_q) begin
            health_d = (health_q == 3'd0) ? 3'd0 : health_q - 3'd1;
            cnt_d    = CNT_W'(INVULN_FRAMES);
            state_d  = (health_d == 3'd0) ? DEAD : INVULN;
          end
        end
        INVULN: begin
          hit_d = overlap_q;
          if (cnt_q <= CNT_W'(1)) begin
            cnt_d   = '0;
            state_d = ARMED;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        DEAD: begin
          health_d = 3'd0;
        end
        default: begin
          state_d = ARMED;
        end
      endcase
    end
  end

  assign is_hit        = hit_q;
  assign player_health = health_q;
  assign player_dead   = (state_q == DEAD);
  assign dbg_state     = state_q;

`ifdef HIT_FLASH_EN
  assign hit_flash = (state_q == INVULN) ? cnt_q[2] : 1'b0;
`else
  assign hit_flash = 1'b0;
`endif

endmodule

// File: doc/projectile_hit_detector.md
PROJECTILE_HIT_DETECTOR -- requirements
Module: projectile_hit_detector

Interface
REQ-001 SHALL have parameter NUM_PROJ, default 4, number of boss projectiles monitored.
REQ-002 SHALL have parameter MAX_HEALTH, default 5, player health after reset.
REQ-003 SHALL have parameter INVULN_FRAMES, default 60, frames of invulnerability after a hit.
REQ-004 SHALL have port Clk  input  1  system clock; the only clock.
REQ-005 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port frame_clk  input  1  vertical-sync frame tick, asynchronous to pixel content.
REQ-007 SHALL have port DrawX, DrawY  input  10 each  current pixel coordinate.
REQ-008 SHALL have port is_player  input  1  player sprite covers current pixel.
REQ-009 SHALL have port is_missile  input  NUM_PROJ  per-projectile pixel coverage, bit i = projectile i.
REQ-010 SHALL have port is_hit  output  NUM_PROJ  one-Clk pulse per projectile to remove it.
REQ-011 SHALL have port player_health  output  3  remaining health.
REQ-012 SHALL have port player_dead  output  1  health reached zero.
REQ-013 SHALL have port hit_flash  output  1  blink enable for player sprite.

Function
REQ-014 SHALL detect the frame_clk rising edge by registering frame_clk, then registering (frame_clk & ~delayed) as frame_edge; frame_edge SHALL be high for exactly one Clk.
REQ-015 SHALL set overlap bit i on any Clk where is_player & is_missile[i] and DrawX<640 and DrawY<480.
REQ-016 SHALL, on the Clk where frame_edge is high, clear all overlap bits and then OR in that cycle's sample (edge-cycle sample belongs to the new frame).
REQ-017 SHALL use FSM states ARMED, INVULN, DEAD.
REQ-018 SHALL, in ARMED on frame_edge with any overlap bit set, decrement player_health by 1, load invuln counter with INVULN_FRAMES, go to INVULN; if the decremented value is 0, go to DEAD instead.
REQ-019 SHALL, in ARMED or INVULN on frame_edge, drive is_hit = overlap bits on the next Clk for exactly one Clk; multiple simultaneous overlaps SHALL cost only 1 health.
REQ-020 SHALL, in INVULN, decrement invuln counter on each frame_edge, never change health, and return to ARMED on the frame_edge where counter is 1.
REQ-021 SHALL, in DEAD, hold player_health=0, player_dead=1, is_hit=0; leave DEAD only by Reset.
REQ-022 SHALL saturate player_health at 0; no underflow.
REQ-023 SHALL ignore is_missile and is_player changes between frame edges except via overlap latches; outputs change only on Clk.

Reset
REQ-024 SHALL on Reset set state ARMED, player_health=MAX_HEALTH, player_dead=0, is_hit=0, hit_flash=0, overlap bits=0, invuln counter=0, frame edge registers=0.
REQ-025 SHALL give Reset priority over every event, including a frame_edge in the same Clk and reset mid-INVULN.

Configuration
REQ-026 SHALL, with HIT_FLASH_EN defined, drive hit_flash = invuln counter bit 2 while in INVULN (toggles every 4 frames) and 0 otherwise.
REQ-027 SHALL, without HIT_FLASH_EN, tie hit_flash to 0 and omit the flash logic.

Structure
REQ-028 SHALL place the state enum (ARMED/INVULN/DEAD), screen limits 640/480 and default MAX_HEALTH in shared package boss_game_pkg.
REQ-029 SHALL instantiate sub-module frame_edge_detect (Clk, Reset, frame_clk -> frame_edge) implementing REQ-014.

Verification
REQ-030 SHALL test single hit: overlap of bit 0 at (100,200) in frame 1 -> after next frame_edge, is_hit=4'b0001 for one Clk, health 5->4, state INVULN.
REQ-031 SHALL test double overlap: bits 1 and 3 in one frame -> is_hit=4'b1010 one Clk, health decrements by exactly 1.
REQ-032 SHALL test invulnerability: hit during INVULN frame 10 -> is_hit pulses, health unchanged; after 60 frames state ARMED; hit_flash toggles every 4 frames when HIT_FLASH_EN defined, stays 0 when undefined.
REQ-033 SHALL test death: five separated hits -> health 0, player_dead=1, further overlaps produce is_hit=0.
REQ-034 SHALL test off-screen and edge-cycle: overlap at DrawX=700 -> no latch; overlap on frame_edge cycle -> reported at following frame_edge.
REQ-035 SHALL test reset mid-INVULN coincident with frame_edge -> health=5, state ARMED, is_hit=0 next Clk.
